// File: rtl/pattern_checker.sv
// pattern_checker: compares an incoming pixel stream against a selected
// test pattern, counts mismatches per frame and records the first one.
// Mode and const_val are latched on arm so mid-frame changes are harmless.
module pattern_checker (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  Mode,
   input  logic [11:0] const_val,
   input  logic        f_sync,
   input  logic        pix_valid,
   input  logic [11:0] pix_data,
   input  logic        endLine,
   input  logic        endFrame,
   output logic        busy,
   output logic        frame_done,
   output logic        pass,
   output logic [15:0] err_cnt,
   output logic [11:0] first_err_x,
   output logic [11:0] first_err_y,
   output logic        sync_err
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_SYNC = 2'd1,
      CHECK     = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  mode_q, mode_d;
   logic [11:0] const_q, const_d;
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [11:0] fex_q, fex_d;
   logic [11:0] fey_q, fey_d;
   logic        seen_q, seen_d;
   logic        pass_q, pass_d;
   logic        sync_err_q, sync_err_d;

   logic [11:0] expected;
   logic        cb1;
   logic        cb2;
   logic        mismatch;
   logic [15:0] err_cnt_inc;

   // Expected pixel at the current (x, y) for the latched pattern
   always_comb begin
      cb1      = x_q[0] ^ y_q[0];
      cb2      = x_q[1] ^ y_q[1];
      expected = 12'h000;
      case (mode_q)
         3'd1:    expected = x_q;
         3'd2:    expected = const_q;
         3'd3:    expected = cb1 ? 12'h000 : 12'hFFF;
         3'd4:    expected = cb1 ? 12'hFFF : 12'h000;
         3'd5:    expected = cb2 ? 12'h000 : 12'hFFF;
         3'd6:    expected = cb2 ? 12'hFFF : 12'h000;
         3'd7:    expected = x_q + y_q;
         default: expected = 12'h000;
      endcase
      mismatch    = (pix_data != expected);
      // Saturating count including the pixel currently on the bus
      err_cnt_inc = (mismatch && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
   end

   // Next-state and datapath update for the frame checker
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      const_d    = const_q;
      x_d        = x_q;
      y_d        = y_q;
      err_cnt_d  = err_cnt_q;
      fex_d      = fex_q;
      fey_d      = fey_q;
      seen_d     = seen_q;
      pass_d     = pass_q;
      sync_err_d = sync_err_q;

      case (state_q)
         IDLE: begin
            if (start && (Mode != 3'd0)) begin
               mode_d     = Mode;
               const_d    = const_val;
               sync_err_d = 1'b0;
               state_d    = WAIT_SYNC;
            end
         end
         WAIT_SYNC: begin
            if (f_sync) begin
               state_d   = CHECK;
               x_d       = 12'd0;
               y_d       = 12'd0;
               err_cnt_d = 16'd0;
               pass_d    = 1'b0;
               fex_d     = 12'd0;
               fey_d     = 12'd0;
               seen_d    = 1'b0;
            end
         end
         CHECK: begin
            if (f_sync) begin
               // Frame restart; a pixel in the same cycle is dropped
               sync_err_d = 1'b1;
               x_d        = 12'd0;
               y_d        = 12'd0;
               err_cnt_d  = 16'd0;
               pass_d     = 1'b0;
               fex_d      = 12'd0;
               fey_d      = 12'd0;
               seen_d     = 1'b0;
            end else if (pix_valid) begin
               err_cnt_d = err_cnt_inc;
               if (mismatch && !seen_q) begin
                  fex_d  = x_q;
                  fey_d  = y_q;
                  seen_d = 1'b1;
               end
               if (endFrame) begin
                  // pass is settled here so it is valid alongside frame_done
                  x_d     = 12'd0;
                  y_d     = 12'd0;
                  pass_d  = (err_cnt_inc == 16'd0);
                  state_d = DONE;
               end else if (endLine) begin
                  x_d = 12'd0;
                  y_d = y_q + 12'd1;
               end else begin
                  x_d = x_q + 12'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mode_q     <= 3'd0;
         const_q    <= 12'd0;
         x_q        <= 12'd0;
         y_q        <= 12'd0;
         err_cnt_q  <= 16'd0;
         fex_q      <= 12'd0;
         fey_q      <= 12'd0;
         seen_q     <= 1'b0;
         pass_q     <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         const_q    <= const_d;
         x_q        <= x_d;
         y_q        <= y_d;
         err_cnt_q  <= err_cnt_d;
         fex_q      <= fex_d;
         fey_q      <= fey_d;
         seen_q     <= seen_d;
         pass_q     <= pass_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign busy        = (state_q == WAIT_SYNC) || (state_q == CHECK);
   assign frame_done  = (state_q == DONE);
   assign pass        = pass_q;
   assign err_cnt     = err_cnt_q;
   assign first_err_x = fex_q;
   assign first_err_y = fey_q;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_pattern_checker.sv
// tb_pattern_checker: randomized and directed frames against a
// pattern-level reference model of the checker.
module tb_pattern_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  Mode;
   logic [11:0] const_val;
   logic        f_sync;
   logic        pix_valid;
   logic [11:0] pix_data;
   logic        endLine;
   logic        endFrame;
   logic        busy;
   logic        frame_done;
   logic        pass;
   logic [15:0] err_cnt;
   logic [11:0] first_err_x;
   logic [11:0] first_err_y;
   logic        sync_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model of the current frame
   int m_cnt;
   int m_fx;
   int m_fy;
   bit m_seen;

   always #5 clk = ~clk;

   pattern_checker dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .Mode        (Mode),
      .const_val   (const_val),
      .f_sync      (f_sync),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .endLine     (endLine),
      .endFrame    (endFrame),
      .busy        (busy),
      .frame_done  (frame_done),
      .pass        (pass),
      .err_cnt     (err_cnt),
      .first_err_x (first_err_x),
      .first_err_y (first_err_y),
      .sync_err    (sync_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Pattern value from the checkerboard / ramp definitions
   function automatic logic [11:0] ref_pix(input int mode, input int cv, input int x, input int y);
      int cell1;
      int cell2;
      cell1 = (x + y) % 2;
      cell2 = (x / 2 + y / 2) % 2;
      case (mode)
         1:       return 12'(x % 4096);
         2:       return 12'(cv);
         3:       return (cell1 != 0) ? 12'h000 : 12'hFFF;
         4:       return (cell1 != 0) ? 12'hFFF : 12'h000;
         5:       return (cell2 != 0) ? 12'h000 : 12'hFFF;
         6:       return (cell2 != 0) ? 12'hFFF : 12'h000;
         7:       return 12'((x + y) % 4096);
         default: return 12'h000;
      endcase
   endfunction

   task automatic model_clear();
      m_cnt  = 0;
      m_fx   = 0;
      m_fy   = 0;
      m_seen = 0;
   endtask

   task automatic model_pixel(input int x, input int y, input bit bad);
      if (bad) begin
         if (!m_seen) begin
            m_seen = 1;
            m_fx   = x % 4096;
            m_fy   = y % 4096;
         end
         if (m_cnt < 65535) m_cnt++;
      end
   endtask

   task automatic begin_frame(input int mode, input int cv);
      @(negedge clk);
      start = 1'b1; Mode = 3'(mode); const_val = 12'(cv);
      @(negedge clk);
      start = 1'b0; Mode = 3'($urandom); const_val = 12'($urandom);
      check_eq("busy_after_start", 32'(busy), 1);
      check_eq("sync_err_cleared_on_start", 32'(sync_err), 0);
      f_sync = 1'b1;
      @(negedge clk);
      f_sync = 1'b0;
      check_eq("err_cnt_cleared_on_sync", 32'(err_cnt), 0);
      check_eq("pass_cleared_on_sync", 32'(pass), 0);
      check_eq("sync_err_after_wait_sync", 32'(sync_err), 0);
      model_clear();
   endtask

   // Sends a w x h frame; assumes the checker is already in CHECK
   task automatic run_frame(input int mode, input int cv, input int w, input int h,
                            input int rate, input bit gaps,
                            input int fx, input int fy, input logic [11:0] fval,
                            input string name);
      logic [11:0] e;
      logic [11:0] d;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            if (gaps) begin
               while ($urandom_range(3) == 0) begin
                  pix_valid = 1'b0; pix_data = 12'($urandom);
                  endLine = 1'($urandom); endFrame = 1'($urandom);
                  start = 1'($urandom); Mode = 3'($urandom); const_val = 12'($urandom);
                  @(negedge clk);
                  check_eq("busy_in_gap", 32'(busy), 1);
               end
            end
            e = ref_pix(mode, cv, x, y);
            d = e;
            if (x == fx && y == fy) d = fval;
            else if ($urandom_range(99) < rate) d = e ^ 12'($urandom_range(1, 4095));
            pix_valid = 1'b1; pix_data = d;
            endLine = (x == w - 1); endFrame = (x == w - 1) && (y == h - 1);
            start = 1'b0; Mode = 3'($urandom); const_val = 12'($urandom);
            @(negedge clk);
            model_pixel(x, y, d != e);
            pix_valid = 1'b0; endLine = 1'b0; endFrame = 1'b0;
            check_eq("err_cnt_running", 32'(err_cnt), 32'(m_cnt));
         end
      end
      check_eq("frame_done_pulse", 32'(frame_done), 1);
      check_eq("busy_in_done", 32'(busy), 0);
      check_eq("pass_at_done", 32'(pass), 32'(m_cnt == 0));
      check_eq("first_err_x", 32'(first_err_x), 32'(m_fx));
      check_eq("first_err_y", 32'(first_err_y), 32'(m_fy));
      @(negedge clk);
      check_eq("frame_done_one_cycle", 32'(frame_done), 0);
      check_eq("err_cnt_hold", 32'(err_cnt), 32'(m_cnt));
      check_eq("pass_hold", 32'(pass), 32'(m_cnt == 0));
      $display("frame %s mode=%0d size=%0dx%0d err_cnt=%0d first=(%0d,%0d) pass=%0b",
               name, mode, w, h, err_cnt, first_err_x, first_err_y, pass);
   endtask

   initial begin
      #3000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int mode;
      int cv;
      rst_n = 1'b0; start = 1'b0; Mode = 3'd0; const_val = 12'd0; f_sync = 1'b0;
      pix_valid = 1'b0; pix_data = 12'd0; endLine = 1'b0; endFrame = 1'b0;
      model_clear();
      #12;
      check_eq("reset_busy", 32'(busy), 0);
      check_eq("reset_frame_done", 32'(frame_done), 0);
      check_eq("reset_err_cnt", 32'(err_cnt), 0);
      check_eq("reset_pass", 32'(pass), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Clean Normal frame, 2 lines of 4 pixels
      begin_frame(1, 0);
      run_frame(1, 0, 4, 2, 0, 0, -1, -1, 12'h000, "normal_4x2");

      // Single flipped checkerboard pixel at (2,1)
      begin_frame(3, 0);
      run_frame(3, 0, 4, 2, 0, 0, 2, 1, 12'hFFF, "cb1x1_white_err");
      check_eq("cb_err_cnt_one", 32'(err_cnt), 1);

      // Randomized frames over all modes
      for (int f = 0; f < 10; f++) begin
         mode = $urandom_range(1, 7);
         cv   = $urandom_range(0, 4095);
         begin_frame(mode, cv);
         run_frame(mode, cv, $urandom_range(1, 8), $urandom_range(1, 4),
                   $urandom_range(0, 40), 1, -1, -1, 12'h000, "random");
      end

      // Mid-frame f_sync restart, then a clean Ramp frame
      begin_frame(7, 0);
      for (int i = 0; i < 3; i++) begin
         pix_valid = 1'b1; pix_data = 12'hABC ^ 12'(i);
         @(negedge clk);
      end
      f_sync = 1'b1; pix_valid = 1'b1; pix_data = 12'h777; endFrame = 1'b1;
      @(negedge clk);
      f_sync = 1'b0; pix_valid = 1'b0; endFrame = 1'b0;
      check_eq("sync_err_set", 32'(sync_err), 1);
      check_eq("restart_err_cnt", 32'(err_cnt), 0);
      check_eq("restart_still_busy", 32'(busy), 1);
      model_clear();
      run_frame(7, 0, 5, 3, 0, 1, -1, -1, 12'h000, "ramp_after_resync");
      check_eq("sync_err_sticky", 32'(sync_err), 1);

      // start with Mode=000 is ignored
      @(negedge clk);
      start = 1'b1; Mode = 3'd0;
      @(negedge clk);
      start = 1'b0;
      check_eq("mode0_start_ignored", 32'(busy), 0);

      // start while busy is ignored: Normal stays latched
      @(negedge clk);
      start = 1'b1; Mode = 3'd1; const_val = 12'h000;
      @(negedge clk);
      start = 1'b1; Mode = 3'd2; const_val = 12'h123;
      @(negedge clk);
      start = 1'b0;
      check_eq("busy_wait_sync", 32'(busy), 1);
      f_sync = 1'b1;
      @(negedge clk);
      f_sync = 1'b0;
      model_clear();
      run_frame(1, 0, 6, 2, 0, 1, -1, -1, 12'h000, "normal_after_busy_start");

      // Constant mode saturation
      begin_frame(2, 12'h5A5);
      run_frame(2, 12'h5A5, 70000, 1, 100, 0, -1, -1, 12'h000, "const_saturate");
      check_eq("err_cnt_saturated", 32'(err_cnt), 32'hFFFF);

      // Reset mid-frame with err_cnt=5
      begin_frame(1, 0);
      for (int x = 0; x < 6; x++) begin
         pix_valid = 1'b1; pix_data = (x == 0) ? 12'h000 : (12'(x) ^ 12'h800);
         @(negedge clk);
      end
      pix_valid = 1'b0;
      check_eq("pre_reset_err_cnt", 32'(err_cnt), 5);
      check_eq("pre_reset_first_x", 32'(first_err_x), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_reset_busy", 32'(busy), 0);
      check_eq("async_reset_err_cnt", 32'(err_cnt), 0);
      check_eq("async_reset_first_x", 32'(first_err_x), 0);
      check_eq("async_reset_first_y", 32'(first_err_y), 0);
      check_eq("async_reset_pass", 32'(pass), 0);
      check_eq("async_reset_frame_done", 32'(frame_done), 0);
      check_eq("async_reset_sync_err", 32'(sync_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      pix_valid = 1'b1; pix_data = 12'h000; endFrame = 1'b1;
      @(negedge clk);
      pix_valid = 1'b0; endFrame = 1'b0;
      check_eq("no_frame_done_after_reset", 32'(frame_done), 0);
      check_eq("idle_after_reset", 32'(busy), 0);
      $display("reset mid-frame sequence complete");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
